serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- RS-232 receive side of the board serial link: the counterpart of the existing transmitter.
- Deserialises 8N1 frames from the RxD pin and presents each byte with a one-cycle strobe.
- Oversampling, a synchroniser and majority filtering reject line glitches.
- Flags stop-bit framing errors and reports line idle (gap between packets).

Parameters:
ClkFrequency, 24000000, system clock frequency in Hz
Baud, 115200, line bit rate
Oversampling, 8, sample ticks per bit; power of two, 4..16
AccWidth, 16, fractional phase-accumulator width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
RxD  input  1  serial line, asynchronous to clk, idle high
RxD_data  output  8  last correctly framed byte
RxD_data_ready  output  1  one-clk strobe, RxD_data just updated
RxD_frame_err  output  1  one-clk strobe, stop bit sampled low
RxD_busy  output  1  high while a frame is in progress (state != IDLE)
RxD_idle  output  1  line high for >= 10 bit times since the last frame

Behaviour:
- Reset (async on rst_n low, regardless of state, including mid-frame):
  - state=IDLE; all counters 0; synchroniser and filter history all 1.
  - RxD_data=0x00; RxD_data_ready=0; RxD_frame_err=0; RxD_busy=0; RxD_idle=0.
- Tick generator:
  - AccWidth+1-bit accumulator, free-running (including in IDLE).
  - Each clk: acc <= acc[AccWidth-1:0] + Inc, where Inc = round(Baud*Oversampling*2^AccWidth/ClkFrequency).
  - tick = acc[AccWidth].
  - Inc is computed with rounding at elaboration; Inc must be < 2^AccWidth, i.e. Baud*Oversampling < ClkFrequency.
- Input path:
  - 2-FF synchroniser, reset to 1.
  - On each tick, shift the synchronised bit into a 3-bit history; the filtered bit is the majority of the 3.
  - The filtered bit only changes on ticks.
- State machine (advances only on tick; tick counter cnt counts ticks within the current bit):
  - IDLE: filtered=0 -> START, cnt=0.
  - START: at cnt=Oversampling/2-1 (mid start bit), re-check filtered:
    - filtered=0 -> DATA, cnt=0, bitidx=0.
    - filtered=1 -> IDLE (glitch reject, no strobe).
  - DATA: at cnt=Oversampling-1 shift filtered into shift register, LSB first; bitidx++. After bitidx=7 -> STOP.
  - STOP: at cnt=Oversampling-1:
    - filtered=1: RxD_data <= shift register; RxD_data_ready=1 for the next clk only.
    - filtered=0: RxD_frame_err=1 for one clk; RxD_data unchanged.
    - Either case -> IDLE immediately, so a back-to-back start bit is caught.
- Latency: strobe on the clk after the mid-stop-bit tick, ~9.5 bit times + 2 clk + filter delay after the start edge.
- RxD_data_ready and RxD_frame_err are never high simultaneously.
- Idle detect:
  - Gap counter clears on any tick with filtered=0; saturates at 10*Oversampling ticks.
  - RxD_idle=1 while saturated and state=IDLE.
  - Drops on the first low filtered sample.
- Line held low (break): frame_err pulse once, then a new START only after a low following filtered=1; RxD_idle stays 0.

Decomposition:
- Package serial_pkg holds:
  - state encoding: IDLE, START, DATA, STOP
  - FRAME_BITS=10
  - the rounded-increment function, shared with the transmitter.
- One sub-module: serial_baud_tick (accumulator + tick output, parameters ClkFrequency, Rate, AccWidth). The transmitter can reuse it later.

Test Plan:
All cases use ClkFrequency=1843200, Baud=115200, Oversampling=8: tick every 2 clk, 1 bit = 16 clk.
1. Drive frame 0x55 with stop=1 -> exactly one RxD_data_ready, RxD_data=0x55, RxD_frame_err=0; strobe 150-160 clk after the start edge.
2. Low pulse of 4 clk on an idle line -> no strobe, RxD_busy returns to 0 within 10 clk, RxD_data unchanged.
3. Frame 0xA3 with stop=0 after case 1 -> one RxD_frame_err pulse, RxD_data stays 0x55, no data_ready.
4. Back-to-back frames 0x00 then 0xFF, no gap -> two data_ready strobes 160±2 clk apart, data 0x00 then 0xFF.
5. rst_n low for 3 clk during data bit 4 of 0x3C, then a fresh 0x3C -> all outputs reset immediately; only the fresh frame yields data_ready with 0x3C.
6. Line high 200 clk after a frame -> RxD_idle rises at ~160 clk post-stop; next start bit clears it within 6 clk.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the board serial link (receiver now, transmitter later).
//   rx_state_t : receiver frame state encoding
//   FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   baud_inc   : rounded phase-accumulator increment for a given tick rate
//   maj3       : majority vote of three samples
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned FRAME_BITS = 10;

    // round(rate * 2^acc_width / clk_hz), evaluated at elaboration
    function automatic longint unsigned baud_inc(
        input longint unsigned clk_hz,
        input longint unsigned rate,
        input int unsigned     acc_width
    );
        return ((rate << acc_width) + (clk_hz >> 1)) / clk_hz;
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Fractional phase-accumulator tick generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-clk pulse at an average rate of Rate per second
// Rate must be below ClkFrequency so the increment fits in AccWidth bits.
module serial_baud_tick
    import serial_pkg::*;
#(
    parameter int unsigned ClkFrequency = 24000000,
    parameter int unsigned Rate         = 921600,
    parameter int unsigned AccWidth     = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned     ACC_W = AccWidth + 1;
    localparam longint unsigned INC   = baud_inc(64'(ClkFrequency), 64'(Rate), AccWidth);

    logic [AccWidth:0] acc;

    // Free-running; the carry out of the fractional part is the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[AccWidth-1:0]} + ACC_W'(INC);
        end
    end

    assign tick = acc[AccWidth];

endmodule

// File: rtl/serial_receiver.sv
// RS-232 8N1 receiver with oversampling, synchroniser and majority filter.
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   RxD            : serial line, asynchronous, idle high
//   RxD_data       : last correctly framed byte
//   RxD_data_ready : one-clk strobe, RxD_data just updated
//   RxD_frame_err  : one-clk strobe, stop bit sampled low
//   RxD_busy       : frame in progress
//   RxD_idle       : line high for at least one frame time since last frame
module serial_receiver
    import serial_pkg::*;
#(
    parameter int unsigned ClkFrequency = 24000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned Oversampling = 8,
    parameter int unsigned AccWidth     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_busy,
    output logic       RxD_idle
);

    localparam int unsigned     CNT_W   = $clog2(Oversampling);
    localparam int unsigned     GAP_MAX = FRAME_BITS * Oversampling;
    localparam int unsigned     GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(Oversampling / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(Oversampling - 1);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(GAP_MAX);

    logic             tick;
    logic [1:0]       sync;
    logic [2:0]       hist;
    logic             filtered;
    logic             filtered_next;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitidx;
    logic [7:0]       shreg;
    logic             armed;
    logic [GAP_W-1:0] gap;

    serial_baud_tick #(
        .ClkFrequency (ClkFrequency),
        .Rate         (Baud * Oversampling),
        .AccWidth     (AccWidth)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchroniser and tick-rate sample history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            hist <= 3'b111;
        end else begin
            sync <= {sync[0], RxD};
            if (tick) begin
                hist <= {hist[1:0], sync[1]};
            end
        end
    end

    assign filtered = maj3(hist);
    // Value the filter takes after this clk; lets idle drop on the same edge
    assign filtered_next = tick ? maj3({hist[1:0], sync[1]}) : filtered;

    // Frame state machine; advances on ticks, strobes last one clk.
    // armed blocks re-triggering on a line that stayed low through a bad stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bitidx         <= '0;
            shreg          <= '0;
            armed          <= 1'b1;
            RxD_data       <= '0;
            RxD_data_ready <= 1'b0;
            RxD_frame_err  <= 1'b0;
            RxD_busy       <= 1'b0;
        end else begin
            RxD_data_ready <= 1'b0;
            RxD_frame_err  <= 1'b0;
            if (tick) begin
                if (filtered) begin
                    armed <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (!filtered && armed) begin
                            state    <= START;
                            cnt      <= '0;
                            RxD_busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == CNT_MID) begin
                            cnt    <= '0;
                            bitidx <= '0;
                            if (!filtered) begin
                                state <= DATA;
                            end else begin
                                state    <= IDLE;
                                RxD_busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_END) begin
                            cnt    <= '0;
                            shreg  <= {filtered, shreg[7:1]};
                            bitidx <= bitidx + 3'd1;
                            if (bitidx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == CNT_END) begin
                            cnt      <= '0;
                            state    <= IDLE;
                            RxD_busy <= 1'b0;
                            if (filtered) begin
                                RxD_data       <= shreg;
                                RxD_data_ready <= 1'b1;
                            end else begin
                                RxD_frame_err <= 1'b1;
                                armed         <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        RxD_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gap counter: ticks of high line, saturating at one frame time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap      <= '0;
            RxD_idle <= 1'b0;
        end else begin
            if (tick) begin
                if (!filtered) begin
                    gap <= '0;
                end else if (gap != GAP_SAT) begin
                    gap <= gap + GAP_W'(1);
                end
            end
            RxD_idle <= (gap == GAP_SAT) && (state == IDLE) && filtered_next;
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver at 1843200 Hz / 115200 baud / x8 (16 clk per bit).
module tb_serial_receiver;

    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_busy;
    logic       RxD_idle;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks       = 0;
    int   n_errors       = 0;
    int   cyc            = 0;
    int   n_ready        = 0;
    int   n_err          = 0;
    int   last_ready_cyc = 0;
    int   prev_ready_cyc = 0;

    serial_receiver #(
        .ClkFrequency (1843200),
        .Baud         (115200),
        .Oversampling (8),
        .AccWidth     (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_frame_err  (RxD_frame_err),
        .RxD_busy       (RxD_busy),
        .RxD_idle       (RxD_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic expect_evt(input logic err, input logic [7:0] data);
        exp_q.push_back({err, data});
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Output monitor: every strobe must match the next scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (RxD_data_ready || RxD_frame_err)) begin
            check("strobe_exclusive", 32'(RxD_data_ready && RxD_frame_err), 32'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(RxD_frame_err), 32'(e.err));
                check("strobe_data", 32'(RxD_data), 32'(e.data));
            end
            if (RxD_data_ready) begin
                n_ready++;
                prev_ready_cyc = last_ready_cyc;
                last_ready_cyc = cyc;
            end else begin
                n_err++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         r0;
        int         e0;
        int         t0;
        int         lat;
        int         rise;
        logic       seen;
        logic [7:0] d;

        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data",  32'(RxD_data), 32'(8'h00));
        check("rst_ready", 32'(RxD_data_ready), 32'(0));
        check("rst_err",   32'(RxD_frame_err), 32'(0));
        check("rst_busy",  32'(RxD_busy), 32'(0));
        check("rst_idle",  32'(RxD_idle), 32'(0));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 1: good frame 0x55
        r0 = n_ready; e0 = n_err;
        expect_evt(1'b0, 8'h55);
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        check("f1_ready_cnt", 32'(n_ready - r0), 32'(1));
        check("f1_err_cnt",   32'(n_err - e0), 32'(0));
        check("f1_data",      32'(RxD_data), 32'(8'h55));
        lat = last_ready_cyc - t0;
        check("f1_latency_150_160", 32'(lat >= 150 && lat <= 160), 32'(1));

        // 2: 4-clk glitch on an idle line
        r0 = n_ready; e0 = n_err;
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy", 32'(RxD_busy), 32'(0));
        repeat (20) @(negedge clk);
        check("glitch_ready_cnt", 32'(n_ready - r0), 32'(0));
        check("glitch_err_cnt",   32'(n_err - e0), 32'(0));
        check("glitch_data",      32'(RxD_data), 32'(8'h55));

        // 3: bad stop bit
        r0 = n_ready; e0 = n_err;
        expect_evt(1'b1, 8'h55);
        send_frame(8'hA3, 1'b0);
        RxD = 1'b1;
        repeat (30) @(negedge clk);
        check("ferr_err_cnt",   32'(n_err - e0), 32'(1));
        check("ferr_ready_cnt", 32'(n_ready - r0), 32'(0));
        check("ferr_data",      32'(RxD_data), 32'(8'h55));

        // 4: back-to-back frames
        r0 = n_ready;
        expect_evt(1'b0, 8'h00);
        expect_evt(1'b0, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (30) @(negedge clk);
        check("b2b_ready_cnt", 32'(n_ready - r0), 32'(2));
        lat = last_ready_cyc - prev_ready_cyc;
        check("b2b_spacing_158_162", 32'(lat >= 158 && lat <= 162), 32'(1));
        check("b2b_data", 32'(RxD_data), 32'(8'hFF));

        // 5: reset during data bit 4, then a fresh frame
        repeat (20) @(negedge clk);
        d = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        RxD = d[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  32'(RxD_data), 32'(8'h00));
        check("mid_rst_busy",  32'(RxD_busy), 32'(0));
        check("mid_rst_ready", 32'(RxD_data_ready), 32'(0));
        check("mid_rst_idle",  32'(RxD_idle), 32'(0));
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        r0 = n_ready;
        expect_evt(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (30) @(negedge clk);
        check("rst_frame_ready_cnt", 32'(n_ready - r0), 32'(1));
        check("rst_frame_data",      32'(RxD_data), 32'(8'h3C));

        // 6: idle detection after the frame, cleared by the next start bit
        repeat (70) @(negedge clk);
        check("idle_early", 32'(RxD_idle), 32'(0));
        seen = 1'b0;
        rise = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!seen && RxD_idle) begin
                seen = 1'b1;
                rise = 101 + i;
            end
        end
        check("idle_rise", 32'(seen), 32'(1));
        check("idle_rise_130_175", 32'(rise >= 130 && rise <= 175), 32'(1));
        expect_evt(1'b0, 8'h81);
        RxD  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(negedge clk);
            if (i < 6 && !RxD_idle) seen = 1'b1;
        end
        check("idle_clear_6clk", 32'(seen), 32'(1));
        check("busy_in_frame",   32'(RxD_busy), 32'(1));
        d = 8'h81;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        repeat (30) @(negedge clk);
        check("f81_data", 32'(RxD_data), 32'(8'h81));

        // 7: line held low (break)
        r0 = n_ready; e0 = n_err;
        expect_evt(1'b1, 8'h81);
        RxD = 1'b0;
        repeat (400) @(negedge clk);
        check("break_err_cnt",   32'(n_err - e0), 32'(1));
        check("break_ready_cnt", 32'(n_ready - r0), 32'(0));
        check("break_idle",      32'(RxD_idle), 32'(0));
        RxD = 1'b1;
        repeat (40) @(negedge clk);
        check("break_release_err_cnt", 32'(n_err - e0), 32'(1));
        check("break_release_busy",    32'(RxD_busy), 32'(0));

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
